// File: rtl/run_event_counter_if.sv
// Bundles the detector flag, the control inputs and the counter/display outputs
// of run_event_counter. The master drives det/en/clr; the counter is the slave.
interface run_event_counter_if #(
  parameter int RUN_W = 8
);
  logic             det;
  logic             en;
  logic             clr;
  logic             evt;
  logic [7:0]       count_bcd;
  logic             ovf;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] max_len;
  logic [6:0]       seg0;
  logic [6:0]       seg1;

  modport master (
    output det, en, clr,
    input  evt, count_bcd, ovf, run_len, max_len, seg0, seg1
  );

  modport slave (
    input  det, en, clr,
    output evt, count_bcd, ovf, run_len, max_len, seg0, seg1
  );
endinterface

// File: rtl/run_event_counter.sv
// Counts detection episodes (0->1 transitions of det) in a two-digit BCD counter,
// measures the length of each episode in cycles, keeps the longest completed one,
// and drives both digits to active-low 7-segment displays.
module run_event_counter #(
  parameter int RUN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  run_event_counter_if.slave bus
);

  localparam logic [0:0]       S_IDLE  = 1'b0;
  localparam logic [0:0]       S_RUN   = 1'b1;
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  // BCD increment of a two-digit value; bit 8 flags the 99->00 wrap.
  // Digits are clamped so an out-of-range digit still rolls over to 0.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    logic       wrap;
    ones = v[3:0];
    tens = v[7:4];
    wrap = 1'b0;
    if (ones >= 4'd9) begin
      ones = 4'd0;
      if (tens >= 4'd9) begin
        tens = 4'd0;
        wrap = 1'b1;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      ones = ones + 4'd1;
    end
    return {wrap, tens, ones};
  endfunction

  // Active-low segment code, bit order {g,f,e,d,c,b,a}; non-digits show 0.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [0:0]       r_state;
  logic             r_det_q;
  logic             r_evt;
  logic [7:0]       r_count_bcd;
  logic             r_ovf;
  logic [RUN_W-1:0] r_run_len;
  logic [RUN_W-1:0] r_max_len;

  logic             w_rise;
  logic [8:0]       w_inc;

  assign w_rise = bus.det & ~r_det_q;
  assign w_inc  = bcd_inc(r_count_bcd);

  // Previous-cycle sample of det; tracks det even while disabled or clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_det_q <= 1'b0;
    end else begin
      r_det_q <= bus.det;
    end
  end

  // Episode FSM, BCD event counter, overflow flag and run/max length tracking.
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      r_state     <= S_IDLE;
      r_evt       <= 1'b0;
      r_count_bcd <= 8'h00;
      r_ovf       <= 1'b0;
      r_run_len   <= {RUN_W{1'b0}};
      r_max_len   <= {RUN_W{1'b0}};
    end else begin
      r_evt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A flag that was already high when enabled is not a new episode.
          if (bus.en && w_rise) begin
            r_state     <= S_RUN;
            r_run_len   <= {{(RUN_W-1){1'b0}}, 1'b1};
            r_evt       <= 1'b1;
            r_count_bcd <= w_inc[7:0];
            if (w_inc[8]) begin
              r_ovf <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!bus.en) begin
            // Disabled mid-episode: discard it without touching max_len.
            r_state   <= S_IDLE;
            r_run_len <= {RUN_W{1'b0}};
          end else if (bus.det) begin
            if (r_run_len != RUN_MAX) begin
              r_run_len <= r_run_len + {{(RUN_W-1){1'b0}}, 1'b1};
            end
          end else begin
            r_state   <= S_IDLE;
            r_run_len <= {RUN_W{1'b0}};
            if (r_run_len > r_max_len) begin
              r_max_len <= r_run_len;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_run_len <= {RUN_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.evt       = r_evt;
  assign bus.count_bcd = r_count_bcd;
  assign bus.ovf       = r_ovf;
  assign bus.run_len   = r_run_len;
  assign bus.max_len   = r_max_len;
  assign bus.seg0      = seg_decode(r_count_bcd[3:0]);
  assign bus.seg1      = seg_decode(r_count_bcd[7:4]);

endmodule

// File: tb/tb_run_event_counter.sv
// Self-checking bench for run_event_counter: a cycle model pushes the expected
// output vector for every driven cycle; each test pops and compares after the edge.
module tb_run_event_counter;

  localparam int RUN_W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  run_event_counter_if #(.RUN_W(RUN_W)) bus ();

  run_event_counter #(.RUN_W(RUN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef logic [39:0] pk_t;

  int  checks   = 0;
  int  failures = 0;
  pk_t sb[$];

  // Reference model state (integer arithmetic, count held in binary 0..99).
  logic m_st, m_dq, m_evt, m_ovf;
  int   m_cnt, m_run, m_max;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic pk_t m_pack();
    return {m_evt, 4'(m_cnt / 10), 4'(m_cnt % 10), m_ovf, 8'(m_run), 8'(m_max),
            seg_tab[m_cnt % 10], seg_tab[m_cnt / 10]};
  endfunction

  function automatic pk_t obs_pack();
    return {bus.evt, bus.count_bcd, bus.ovf, bus.run_len, bus.max_len, bus.seg0, bus.seg1};
  endfunction

  // Drive one cycle, advance the model, queue its expectation, step past the edge.
  task automatic cyc(input logic d, input logic e, input logic c, input logic r);
    bus.det = d; bus.en = e; bus.clr = c; reset = r;
    if (r) begin
      m_st = 1'b0; m_dq = 1'b0; m_evt = 1'b0; m_ovf = 1'b0;
      m_cnt = 0; m_run = 0; m_max = 0;
    end else begin
      if (c) begin
        m_st = 1'b0; m_evt = 1'b0; m_ovf = 1'b0; m_cnt = 0; m_run = 0; m_max = 0;
      end else begin
        m_evt = 1'b0;
        if (!m_st) begin
          if (e && d && !m_dq) begin
            m_st = 1'b1; m_run = 1; m_evt = 1'b1; m_cnt = m_cnt + 1;
            if (m_cnt == 100) begin m_cnt = 0; m_ovf = 1'b1; end
          end
        end else if (!e) begin
          m_st = 1'b0; m_run = 0;
        end else if (d) begin
          if (m_run < 255) m_run = m_run + 1;
        end else begin
          if (m_run > m_max) m_max = m_run;
          m_run = 0; m_st = 1'b0;
        end
      end
      m_dq = d;
    end
    sb.push_back(m_pack());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    pk_t e, o;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      e = sb.pop_front(); o = obs_pack(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset step=%0d got=%h exp=%h", i, o, e); end
    end
    checks++;
    if ({bus.count_bcd, bus.evt, bus.ovf, bus.run_len, bus.max_len, bus.seg0, bus.seg1} !==
        {8'h00, 1'b0, 1'b0, 8'd0, 8'd0, 7'h40, 7'h40}) begin
      failures++; $display("FAIL reset_values got cnt=%h seg0=%h seg1=%h exp cnt=00 seg=40/40",
                           bus.count_bcd, bus.seg0, bus.seg1);
    end
  endtask

  task automatic test_basic();
    logic [8:0] pat = 9'b110111100;
    int evts = 0;
    pk_t e, o;
    cyc(1'b0, 1'b1, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 8; i >= 0; i--) begin
      cyc(pat[i], 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs_pack(); checks++;
      if (o !== e) begin failures++; $display("FAIL basic step=%0d got=%h exp=%h", 8 - i, o, e); end
      evts += int'(bus.evt);
    end
    checks++;
    if (evts !== 2) begin failures++; $display("FAIL basic_evts got=%0d exp=2", evts); end
    checks++;
    if ({bus.count_bcd, bus.max_len, bus.seg0, bus.seg1} !== {8'h02, 8'd4, 7'h24, 7'h40}) begin
      failures++; $display("FAIL basic_final got cnt=%h max=%0d seg0=%h seg1=%h exp 02/4/24/40",
                           bus.count_bcd, bus.max_len, bus.seg0, bus.seg1);
    end
  endtask

  task automatic test_already_high();
    logic [3:0] st [9] = '{4'b0001, 4'b1000, 4'b1000, 4'b1100, 4'b1100,
                           4'b1100, 4'b0100, 4'b1100, 4'b0100};
    pk_t e, o;
    for (int i = 0; i < 9; i++) begin
      cyc(st[i][3], st[i][2], st[i][1], st[i][0]);
      e = sb.pop_front(); o = obs_pack(); checks++;
      if (o !== e) begin failures++; $display("FAIL already_high step=%0d got=%h exp=%h", i, o, e); end
      if (i == 5) begin
        checks++;
        if (bus.count_bcd !== 8'h00) begin failures++; $display("FAIL already_high_nocount got=%h exp=00", bus.count_bcd); end
      end
    end
    checks++;
    if (bus.count_bcd !== 8'h01) begin failures++; $display("FAIL already_high_count got=%h exp=01", bus.count_bcd); end
  endtask

  task automatic test_wrap();
    pk_t e, o;
    cyc(1'b0, 1'b1, 1'b0, 1'b1); void'(sb.pop_front());
    for (int ep = 1; ep <= 101; ep++) begin
      for (int k = 0; k < 2; k++) begin
        cyc(k == 0, 1'b1, 1'b0, 1'b0);
        e = sb.pop_front(); o = obs_pack(); checks++;
        if (o !== e) begin failures++; $display("FAIL wrap ep=%0d ph=%0d got=%h exp=%h", ep, k, o, e); end
      end
      if (ep == 10) begin
        checks++;
        if ({bus.count_bcd, bus.seg1} !== {8'h10, 7'h79}) begin failures++; $display("FAIL wrap_10 got cnt=%h seg1=%h exp 10/79", bus.count_bcd, bus.seg1); end
      end
      if (ep == 99) begin
        checks++;
        if ({bus.count_bcd, bus.ovf} !== {8'h99, 1'b0}) begin failures++; $display("FAIL wrap_99 got cnt=%h ovf=%b exp 99/0", bus.count_bcd, bus.ovf); end
      end
      if (ep == 100) begin
        checks++;
        if ({bus.count_bcd, bus.ovf} !== {8'h00, 1'b1}) begin failures++; $display("FAIL wrap_00 got cnt=%h ovf=%b exp 00/1", bus.count_bcd, bus.ovf); end
      end
    end
    checks++;
    if ({bus.count_bcd, bus.ovf} !== {8'h01, 1'b1}) begin failures++; $display("FAIL wrap_01 got cnt=%h ovf=%b exp 01/1", bus.count_bcd, bus.ovf); end
  endtask

  task automatic test_saturate();
    pk_t e, o;
    cyc(1'b0, 1'b1, 1'b0, 1'b1); void'(sb.pop_front());
    for (int i = 0; i < 301; i++) begin
      cyc(i < 300, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); o = obs_pack(); checks++;
      if (o !== e) begin failures++; $display("FAIL saturate step=%0d got=%h exp=%h", i, o, e); end
      if (i == 299) begin
        checks++;
        if (bus.run_len !== 8'd255) begin failures++; $display("FAIL saturate_run got=%0d exp=255", bus.run_len); end
      end
    end
    checks++;
    if ({bus.max_len, bus.run_len} !== {8'd255, 8'd0}) begin failures++; $display("FAIL saturate_max got max=%0d run=%0d exp 255/0", bus.max_len, bus.run_len); end
  endtask

  task automatic test_clr_edge();
    logic [3:0] st [9] = '{4'b0101, 4'b1100, 4'b0100, 4'b1110, 4'b1100,
                           4'b1100, 4'b1100, 4'b0100, 4'b1100};
    pk_t e, o;
    for (int i = 0; i < 9; i++) begin
      cyc(st[i][3], st[i][2], st[i][1], st[i][0]);
      e = sb.pop_front(); o = obs_pack(); checks++;
      if (o !== e) begin failures++; $display("FAIL clr_edge step=%0d got=%h exp=%h", i, o, e); end
      if (i == 3 || i == 6) begin
        checks++;
        if ({bus.count_bcd, bus.evt} !== {8'h00, 1'b0}) begin failures++; $display("FAIL clr_edge_zero step=%0d got cnt=%h evt=%b exp 00/0", i, bus.count_bcd, bus.evt); end
      end
    end
    checks++;
    if ({bus.count_bcd, bus.evt} !== {8'h01, 1'b1}) begin failures++; $display("FAIL clr_edge_recount got cnt=%h evt=%b exp 01/1", bus.count_bcd, bus.evt); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] st [12] = '{4'b0101, 4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b1100,
                            4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b1101, 4'b0100};
    pk_t e, o;
    for (int i = 0; i < 12; i++) begin
      cyc(st[i][3], st[i][2], st[i][1], st[i][0]);
      e = sb.pop_front(); o = obs_pack(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_mid step=%0d got=%h exp=%h", i, o, e); end
      if (i == 9) begin
        checks++;
        if ({bus.run_len, bus.max_len} !== {8'd5, 8'd3}) begin failures++; $display("FAIL reset_mid_pre got run=%0d max=%0d exp 5/3", bus.run_len, bus.max_len); end
      end
      if (i == 10) begin
        checks++;
        if ({bus.evt, bus.count_bcd, bus.ovf, bus.run_len, bus.max_len, bus.seg0, bus.seg1} !==
            {1'b0, 8'h00, 1'b0, 8'd0, 8'd0, 7'h40, 7'h40}) begin
          failures++; $display("FAIL reset_mid_post got cnt=%h run=%0d max=%0d exp 00/0/0", bus.count_bcd, bus.run_len, bus.max_len);
        end
      end
    end
  endtask

  task automatic test_en_abort();
    logic [3:0] st [7] = '{4'b0101, 4'b1100, 4'b1100, 4'b1000, 4'b1100, 4'b0100, 4'b1100};
    pk_t e, o;
    for (int i = 0; i < 7; i++) begin
      cyc(st[i][3], st[i][2], st[i][1], st[i][0]);
      e = sb.pop_front(); o = obs_pack(); checks++;
      if (o !== e) begin failures++; $display("FAIL en_abort step=%0d got=%h exp=%h", i, o, e); end
      if (i == 4) begin
        checks++;
        if ({bus.run_len, bus.max_len, bus.count_bcd} !== {8'd0, 8'd0, 8'h01}) begin
          failures++; $display("FAIL en_abort_discard got run=%0d max=%0d cnt=%h exp 0/0/01", bus.run_len, bus.max_len, bus.count_bcd);
        end
      end
    end
    checks++;
    if (bus.count_bcd !== 8'h02) begin failures++; $display("FAIL en_abort_recount got=%h exp=02", bus.count_bcd); end
  endtask

  initial begin
    bus.det = 1'b0; bus.en = 1'b0; bus.clr = 1'b0; reset = 1'b1;
    test_reset();
    test_basic();
    test_already_high();
    test_wrap();
    test_saturate();
    test_clr_edge();
    test_reset_mid();
    test_en_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_event_counter.md
# run_event_counter

Downstream consumer of the run-detector Moore FSM's 1-bit `out` flag, which is wired to `det`. Each distinct detection episode (0→1 transition of `det`) is counted as one event in a two-digit BCD counter (00–99). The length of each episode is measured in clock cycles and the longest one is retained. Both digits are driven to the board's active-low 7-segment displays.

## Interface
Parameters:
- `RUN_W`, default 8: width of the run-length and max-length registers; saturate at 2^RUN_W−1.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `det`  in  1: detector flag, sampled every rising `clk` edge.
- `en`  in  1: count enable; when 0, events and run lengths are not recorded.
- `clr`  in  1: synchronous clear of count, overflow and max length.
- `evt`  out  1: one-cycle pulse per counted event (registered).
- `count_bcd`  out  8: [7:4] tens digit, [3:0] ones digit, BCD.
- `ovf`  out  1: sticky, set when the count wraps 99→00.
- `run_len`  out  RUN_W: cycles in the current episode (0 when idle).
- `max_len`  out  RUN_W: longest completed episode since reset/clr.
- `seg0`  out  7: ones digit, active-low, bit order {g,f,e,d,c,b,a}.
- `seg1`  out  7: tens digit, same encoding.

## Operation
- `det_q`: previous-cycle sample of `det`, updated every cycle, including when `en`=0 or `clr`=1. It resets to 0.
- Rising edge: `det`=1 and `det_q`=0.
- FSM states: IDLE (reset state) and RUN.
  - IDLE, rising edge, `en`=1 → RUN.
    - `run_len`←1.
    - BCD count increments.
    - `evt`←1 for the next cycle.
  - RUN, `det`=1 → stay in RUN; `run_len`←`run_len`+1, saturating at 2^RUN_W−1.
  - RUN, `det`=0 → IDLE.
    - `max_len`←max(`max_len`, `run_len`).
    - `run_len`←0.
  - RUN, `en`=0 → IDLE immediately. `run_len`←0 and `max_len` is not updated, so the episode is discarded.
  - IDLE, `det`=1 with `det_q`=1 (flag already high when enabled): remain in IDLE and do not count. Counting resumes only after `det` falls and rises again.
- BCD increment:
  - Ones 9→0 carries into tens.
  - 99→00 sets `ovf`.
  - No binary intermediate values; digits never exceed 9.
- Priority: `reset` > `clr` > normal operation.
- `clr`=1:
  - `count_bcd`←00, `ovf`←0, `max_len`←0, `run_len`←0, state←IDLE, `evt`←0.
  - A rising edge in the same cycle is discarded.
- Segment decode is combinational from `count_bcd`. Codes for 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). The all-off code 7F is never produced.
- Reset values:
  - state IDLE, `det_q` 0, `evt` 0, `count_bcd` 00, `ovf` 0, `run_len` 0, `max_len` 0.
  - `seg0` = `seg1` = 40.

## Timing
- All state is updated on the rising `clk` edge. All outputs except `seg0`/`seg1` are registered.
- Latency: `det` sampled high at edge N (with `det_q`=0) → `evt`, `count_bcd` and `run_len`=1 are visible after edge N. `seg*` follow in the same cycle.
- `evt` is high exactly one cycle per episode, regardless of episode length.
- Back-to-back episodes (1,0,1) count twice. The minimum gap is one low cycle.
- `max_len` updates after the edge at which `det` is first sampled 0 in RUN.
- `reset` or `clr` asserted during RUN aborts the episode without a `max_len` update.
- `ovf` is set on the same edge as the 99→00 transition. It is cleared only by `reset` or `clr`.

## Test plan
- Reset, then `det` high for 4 cycles, low 1, high 2, low; `en`=1 → `evt` pulses twice, `count_bcd`=02, `max_len`=4, `seg0`=24, `seg1`=40.
- `det` already high when `en` rises 0→1 → no count. After `det` falls and rises, `count_bcd`=01.
- 100 single-cycle episodes → `count_bcd` goes 09→10 (`seg1`=79), reaches 99, then 00 with `ovf`=1. A further episode gives 01 with `ovf` still 1.
- `det` held high for 300 cycles with RUN_W=8 → `run_len` saturates at 255. After the fall, `max_len`=255.
- `clr` asserted on the same edge as a rising `det` → `count_bcd`=00, no `evt`, `det_q`=1. The flag staying high then produces no count.
- `reset` asserted mid-episode with `run_len`=5 and `max_len`=3 → all outputs return to reset values next cycle. `max_len`=0, not 5.
